// File: rtl/regfile_pkg.sv
// Shared source identifiers, default age limit and byte-enable
// legality check for the register-file write arbiter.
package regfile_pkg;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LD  = 2'd1,
        SRC_PC  = 2'd2
    } src_e;

    localparam int DEF_AGE_LIMIT = 3;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b0111, 4'b1110,
            4'b1111: be_legal = 1'b1;
            default: be_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_wr_slot.sv
// Single-entry write buffer for one source: handshake, payload
// and a saturating age counter used for starvation promotion.
module regfile_wr_slot
    import regfile_pkg::*;
#(
    parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_be,
    input  logic        i_grant,
    output logic        o_valid,
    output logic [4:0]  o_addr,
    output logic [31:0] o_data,
    output logic [3:0]  o_be,
    output logic        o_aged
);

    localparam logic [1:0] LIM = 2'(AGE_LIMIT);

    logic        r_valid;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_be;
    logic [1:0]  r_age;
    logic        w_accept;

    // A granted entry leaves at this edge, so the slot can refill.
    assign o_ready  = !rst && (!r_valid || i_grant);
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_be    <= '0;
            r_age   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
            r_be    <= i_be;
            r_age   <= '0;
        end else if (i_grant) begin
            r_valid <= 1'b0;
            r_age   <= '0;
        end else if (r_valid && r_age != LIM) begin
            r_age <= r_age + 2'd1;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_be    = r_be;
    assign o_aged  = r_valid && (r_age == LIM);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Three-source arbiter onto one register-file write port with
// aging promotion, hazard flags and a sticky byte-enable error.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic        ld_valid,
    input  logic        pc_valid,
    output logic        alu_ready,
    output logic        ld_ready,
    output logic        pc_ready,
    input  logic [4:0]  alu_addr,
    input  logic [4:0]  ld_addr,
    input  logic [4:0]  pc_addr,
    input  logic [31:0] alu_data,
    input  logic [31:0] ld_data,
    input  logic [31:0] pc_data,
    input  logic [3:0]  alu_be,
    input  logic [3:0]  ld_be,
    input  logic [3:0]  pc_be,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    input  logic [4:0]  addr_rs,
    input  logic [4:0]  addr_rt,
    output logic        hz_rs,
    output logic        hz_rt,
    output logic        be_err
);

    logic        w_alu_v, w_ld_v, w_pc_v;
    logic [4:0]  w_alu_a, w_ld_a, w_pc_a;
    logic [31:0] w_alu_d, w_ld_d, w_pc_d;
    logic [3:0]  w_alu_b, w_ld_b, w_pc_b;
    logic        w_alu_aged, w_ld_aged, w_pc_aged;
    logic        w_gnt_alu, w_gnt_ld, w_gnt_pc;
    logic        w_gnt_any;
    src_e        w_gnt_src;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;
    logic [3:0]  w_sel_be;
    logic        w_legal;
    logic        w_write;
    logic        r_be_err;

    regfile_wr_slot #(.AGE_LIMIT(AGE_LIMIT)) u_alu (
        .clk(clk), .rst(rst),
        .i_valid(alu_valid), .o_ready(alu_ready),
        .i_addr(alu_addr), .i_data(alu_data), .i_be(alu_be),
        .i_grant(w_gnt_alu),
        .o_valid(w_alu_v), .o_addr(w_alu_a),
        .o_data(w_alu_d), .o_be(w_alu_b), .o_aged(w_alu_aged)
    );

    regfile_wr_slot #(.AGE_LIMIT(AGE_LIMIT)) u_ld (
        .clk(clk), .rst(rst),
        .i_valid(ld_valid), .o_ready(ld_ready),
        .i_addr(ld_addr), .i_data(ld_data), .i_be(ld_be),
        .i_grant(w_gnt_ld),
        .o_valid(w_ld_v), .o_addr(w_ld_a),
        .o_data(w_ld_d), .o_be(w_ld_b), .o_aged(w_ld_aged)
    );

    regfile_wr_slot #(.AGE_LIMIT(AGE_LIMIT)) u_pc (
        .clk(clk), .rst(rst),
        .i_valid(pc_valid), .o_ready(pc_ready),
        .i_addr(pc_addr), .i_data(pc_data), .i_be(pc_be),
        .i_grant(w_gnt_pc),
        .o_valid(w_pc_v), .o_addr(w_pc_a),
        .o_data(w_pc_d), .o_be(w_pc_b), .o_aged(w_pc_aged)
    );

    // Aged entries first (LD, PC, ALU), then plain ALU > LD > PC.
    always_comb begin
        w_gnt_any = 1'b1;
        w_gnt_src = SRC_ALU;
        if (w_ld_aged)       w_gnt_src = SRC_LD;
        else if (w_pc_aged)  w_gnt_src = SRC_PC;
        else if (w_alu_aged) w_gnt_src = SRC_ALU;
        else if (w_alu_v)    w_gnt_src = SRC_ALU;
        else if (w_ld_v)     w_gnt_src = SRC_LD;
        else if (w_pc_v)     w_gnt_src = SRC_PC;
        else                 w_gnt_any = 1'b0;
    end

    assign w_gnt_alu = w_gnt_any && (w_gnt_src == SRC_ALU);
    assign w_gnt_ld  = w_gnt_any && (w_gnt_src == SRC_LD);
    assign w_gnt_pc  = w_gnt_any && (w_gnt_src == SRC_PC);

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_be   = '0;
        unique case (w_gnt_src)
            SRC_ALU: begin
                w_sel_addr = w_alu_a;
                w_sel_data = w_alu_d;
                w_sel_be   = w_alu_b;
            end
            SRC_LD: begin
                w_sel_addr = w_ld_a;
                w_sel_data = w_ld_d;
                w_sel_be   = w_ld_b;
            end
            SRC_PC: begin
                w_sel_addr = w_pc_a;
                w_sel_data = w_pc_d;
                w_sel_be   = w_pc_b;
            end
            default: ;
        endcase
    end

    assign w_legal = be_legal(w_sel_be);
    assign w_write = w_gnt_any && w_legal && (w_sel_addr != 5'd0);

    assign wr_en   = w_write;
    assign wr_addr = w_write ? w_sel_addr : 5'd0;
    assign wr_data = w_write ? w_sel_data : 32'd0;
    assign wr_be   = w_write ? w_sel_be   : 4'd0;

    always_ff @(posedge clk) begin
        if (rst)
            r_be_err <= 1'b0;
        else if (w_gnt_any && !w_legal)
            r_be_err <= 1'b1;
    end

    assign be_err = r_be_err;

    assign hz_rs = (addr_rs != 5'd0) &&
                   ((w_alu_v && w_alu_a == addr_rs) ||
                    (w_ld_v  && w_ld_a  == addr_rs) ||
                    (w_pc_v  && w_pc_a  == addr_rs));

    assign hz_rt = (addr_rt != 5'd0) &&
                   ((w_alu_v && w_alu_a == addr_rt) ||
                    (w_ld_v  && w_ld_a  == addr_rt) ||
                    (w_pc_v  && w_pc_a  == addr_rt));

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter AGE_LIMIT, default 3, meaning wait cycles before a low-priority entry is promoted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports alu_valid/ld_valid/pc_valid  input  1 each  write request from ALU, load/store and PC-link sources.
REQ-005 SHALL have ports alu_ready/ld_ready/pc_ready  output  1 each  source slot can accept a request this cycle.
REQ-006 SHALL have ports alu_addr/ld_addr/pc_addr  input  5 each  destination register.
REQ-007 SHALL have ports alu_data/ld_data/pc_data  input  32 each  write data.
REQ-008 SHALL have ports alu_be/ld_be/pc_be  input  4 each  byte enables.
REQ-009 SHALL have ports wr_en  output  1, wr_addr  output  5, wr_data  output  32, wr_be  output  4  single register-file write port.
REQ-010 SHALL have ports addr_rs/addr_rt  input  5 each  current read addresses.
REQ-011 SHALL have ports hz_rs/hz_rt  output  1 each  a pending write targets that read address.
REQ-012 SHALL have port be_err  output  1  sticky illegal byte-enable flag.

Function
REQ-013 SHALL hold one single-entry buffer per source (valid, addr, data, be, 2-bit age).
REQ-014 SHALL accept a request when valid and ready are both high at a clock edge; x_ready = buffer empty OR buffer granted this cycle.
REQ-015 SHALL grant at most one valid buffer per cycle; wr_* are driven from the granted buffer in the same cycle, so minimum latency from acceptance to wr_en is 1 cycle.
REQ-016 SHALL use fixed priority ALU > LD > PC, except a LD or PC entry whose age reaches AGE_LIMIT outranks ALU; if both are aged, LD wins.
REQ-017 SHALL increment a valid buffer's age each cycle it is not granted, saturating at AGE_LIMIT, and clear it on grant or load.
REQ-018 SHALL free the granted buffer at the edge; a same-source new request may refill it at that edge (back-to-back at 1 per cycle).
REQ-019 SHALL treat legal be as 0001, 0010, 0100, 1000, 0011, 1100, 0111, 1110, 1111.
REQ-020 SHALL grant and drop an entry with illegal be (wr_en=0 that cycle) and set be_err, which stays high until rst.
REQ-021 SHALL grant and drop an entry with addr 0 (wr_en=0), with no error.
REQ-022 SHALL drive wr_en=1 only for a granted, legal, non-zero-address entry; otherwise wr_addr/wr_data/wr_be=0.
REQ-023 SHALL assert hz_rs (hz_rt) combinationally when any valid buffer has addr equal to addr_rs (addr_rt) and addr != 0.
REQ-024 SHALL issue same-address entries from different sources in grant order; no merging or reordering within a source.

Reset
REQ-025 SHALL, on rst high at an edge, clear all buffers, ages and be_err; requests presented that cycle are not accepted.
REQ-026 SHALL drive all x_ready=0 while rst is high, and wr_en=0, hz_rs=hz_rt=0, be_err=0 in the cycle after reset.
REQ-027 SHALL discard in-flight entries on reset mid-operation; no write issues after that reset edge.

Structure
REQ-028 SHALL place the source enum (SRC_ALU, SRC_LD, SRC_PC), the legal-be check function and AGE_LIMIT default in shared package regfile_pkg.
REQ-029 SHALL use one sub-module, regfile_wr_slot, instantiated per source (buffer, handshake, age counter).

Verification
REQ-030 SHALL test: alu_valid, addr=5, data=0x12345678, be=1111 -> next cycle wr_en=1, wr_addr=5, wr_data=0x12345678.
REQ-031 SHALL test: ALU and LD valid same cycle (addr 3, addr 4) -> ALU issued cycle+1, LD cycle+2; ld_ready low only in the accept-blocked cycle.
REQ-032 SHALL test: ALU requests every cycle with LD pending -> LD issued no later than 4 cycles after its acceptance (AGE_LIMIT=3).
REQ-033 SHALL test: ld_be=0101 -> no write, be_err=1 and stays 1 until rst.
REQ-034 SHALL test: pc_addr=0 -> no write, no error; pending LD to addr 7 with addr_rs=7 -> hz_rs=1 until its grant cycle ends.
REQ-035 SHALL test: rst asserted with all three buffers full -> no write after the reset edge; all ready low during rst and high afterwards.
